// File: rtl/cntr_arb.sv
// cntr_arb: round-robin arbiter granting two requesters bursts of a shared
// twelve-state counter, driven only through cnt_en.
module cntr_arb #(
   parameter int CNT_LAST = 11,
   parameter int LEN_MAX  = 12
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   input  logic [3:0] count_in,
   input  logic       y_in,
   output logic       cnt_en,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic       wrapped,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;
   state_t state;
   logic win, ptr, wflag, win_req, pick, hit, abort;
   logic [3:0] rem, len_w, len_s;
   assign pick    = (req0 & req1) ? ptr : req1;
   assign win_req = win ? req1 : req0;
   assign len_w   = win ? len1 : len0;
   assign len_s   = (len_w > 4'(LEN_MAX)) ? 4'(LEN_MAX) : len_w;
   // terminal flag qualified by the count itself so a stale y_in cannot mark a wrap
   assign hit     = cnt_en & y_in & (count_in == 4'(CNT_LAST));
   assign abort   = (state == GRANT || state == RUN) && !win_req;
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         state   <= IDLE;
         win     <= 1'b0;
         ptr     <= 1'b0;
         rem     <= 4'd0;
         wflag   <= 1'b0;
         cnt_en  <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         wrapped <= 1'b0;
         busy    <= 1'b0;
      end else begin
         done0   <= 1'b0;
         done1   <= 1'b0;
         wrapped <= 1'b0;
         if (abort) begin
            state  <= IDLE;
            cnt_en <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
            ptr    <= ~win;
         end else
            case (state)
               IDLE: if (req0 | req1) begin
                  state <= GRANT;
                  win   <= pick;
                  gnt0  <= ~pick;
                  gnt1  <= pick;
                  busy  <= 1'b1;
                  wflag <= 1'b0;
               end
               GRANT: begin
                  rem <= len_s;
                  if (len_s == 4'd0) begin
                     state <= DONE;
                     done0 <= ~win;
                     done1 <= win;
                  end else begin
                     state  <= RUN;
                     cnt_en <= 1'b1;
                  end
               end
               RUN: begin
                  rem <= rem - 4'd1;
                  if (hit) wflag <= 1'b1;
                  if (rem == 4'd1) begin
                     state   <= DONE;
                     cnt_en  <= 1'b0;
                     done0   <= ~win;
                     done1   <= win;
                     wrapped <= wflag | hit;
                  end
               end
               default: begin
                  state <= IDLE;
                  gnt0  <= 1'b0;
                  gnt1  <= 1'b0;
                  busy  <= 1'b0;
                  ptr   <= ~win;
               end
            endcase
      end
endmodule
